// File: rtl/riscv_opcodes_pkg.sv
// Opcode constants shared by the pipeline.
package riscv_opcodes_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0
endpackage

// File: rtl/riscv_state_pkg.sv
// Pipeline state records: stage instruction and delayed-writeback history entry.
package riscv_state_pkg;
  localparam int RD_MSB = 11;
  localparam int RD_LSB = 7;

  typedef struct packed {
    logic [31:0] instr;
    logic        bubble;
    logic        dbg;
  } instruction_t;

  // Result is kept beside the entry because its width follows MXLEN.
  typedef struct packed {
    logic [31:0] instr;
    logic        bubble;
    logic        dbg;
    logic [4:0]  rd;
  } wb_entry_t;

  function automatic logic [4:0] rd_of(input logic [31:0] instr);
    return instr[RD_MSB:RD_LSB];
  endfunction
endpackage

// File: rtl/riscv_wb_history.sv
// Delayed writeback history: DEPTH-entry shift register of retired results with
// per-port forwarding lookup (youngest match wins, x0 never hits).
module riscv_wb_history
  import riscv_opcodes_pkg::*;
  import riscv_state_pkg::*;
#(
  parameter int MXLEN      = 32,
  parameter int DEPTH      = 2,
  parameter int NUM_RPORTS = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                stall_i,
  input  logic                                flush_i,
  input  instruction_t                        wb_insn_i,
  input  logic                                wb_we_i,
  input  logic [MXLEN-1:0]                    wb_r_i,
  input  logic [NUM_RPORTS-1:0][4:0]          rs_addr_i,
  output logic [NUM_RPORTS-1:0]               fwd_hit_o,
  output logic [NUM_RPORTS-1:0][MXLEN-1:0]    fwd_r_o,
  output instruction_t                        dwb_insn_o,
  output logic [MXLEN-1:0]                    dwb_r_o
);

  wb_entry_t        ent_q [DEPTH];
  wb_entry_t        ent_d [DEPTH];
  logic [MXLEN-1:0] res_q [DEPTH];
  logic [MXLEN-1:0] res_d [DEPTH];

  always_comb begin
    ent_d = ent_q;
    res_d = res_q;
    if (flush_i) begin
      for (int k = 0; k < DEPTH; k++) ent_d[k].bubble = 1'b1;
    end else if (!stall_i) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        ent_d[k] = ent_q[k-1];
        res_d[k] = res_q[k-1];
      end
      ent_d[0].instr  = wb_insn_i.instr;
      ent_d[0].dbg    = wb_insn_i.dbg;
      ent_d[0].bubble = ~wb_we_i;
      ent_d[0].rd     = rd_of(wb_insn_i.instr);
      // A bubble load leaves the old result bits in place.
      if (wb_we_i) res_d[0] = wb_r_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        ent_q[k] <= '{instr: NOP, bubble: 1'b1, dbg: 1'b0, rd: rd_of(NOP)};
        res_q[k] <= '0;
      end
    end else begin
      ent_q <= ent_d;
      res_q <= res_d;
    end
  end

  for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
    logic             hit;
    logic [MXLEN-1:0] r;

    // Scan oldest to youngest so the youngest match overwrites.
    always_comb begin
      hit = 1'b0;
      r   = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (!ent_q[k].bubble && ent_q[k].rd == rs_addr_i[p] && rs_addr_i[p] != 5'd0) begin
          hit = 1'b1;
          r   = res_q[k];
        end
      end
    end

    assign fwd_hit_o[p] = hit;
    assign fwd_r_o[p]   = r;
  end

  assign dwb_insn_o = '{instr: ent_q[0].instr, bubble: ent_q[0].bubble, dbg: ent_q[0].dbg};
  assign dwb_r_o    = res_q[0];

endmodule

// File: tb/tb_riscv_wb_history.sv
// Bench for riscv_wb_history: a DEPTH=2 and a DEPTH=4/3-port instance share stimulus
// and are compared against a queue-style history model.
module tb_riscv_wb_history;
  import riscv_opcodes_pkg::*;
  import riscv_state_pkg::*;

  logic clk = 1'b0;
  logic rst, stall, flush, we;
  instruction_t wb;
  logic [31:0] wr;

  logic [1:0][4:0]  rs2;
  logic [1:0]       hit2;
  logic [1:0][31:0] r2;
  instruction_t     dwb2;
  logic [31:0]      dwbr2;

  logic [2:0][4:0]  rs4;
  logic [2:0]       hit4;
  logic [2:0][31:0] r4;
  instruction_t     dwb4;
  logic [31:0]      dwbr4;

  always #5 clk = ~clk;

  riscv_wb_history #(.MXLEN(32), .DEPTH(2), .NUM_RPORTS(2)) u2 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .wb_insn_i(wb), .wb_we_i(we), .wb_r_i(wr), .rs_addr_i(rs2),
    .fwd_hit_o(hit2), .fwd_r_o(r2), .dwb_insn_o(dwb2), .dwb_r_o(dwbr2));

  riscv_wb_history #(.MXLEN(32), .DEPTH(4), .NUM_RPORTS(3)) u4 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .wb_insn_i(wb), .wb_we_i(we), .wb_r_i(wr), .rs_addr_i(rs4),
    .fwd_hit_o(hit4), .fwd_r_o(r4), .dwb_insn_o(dwb4), .dwb_r_o(dwbr4));

  typedef struct {
    logic [31:0] instr;
    logic        bubble;
    logic        dbg;
    logic [31:0] res;
  } ment_t;

  ment_t mm [2][8];
  int    dep [2] = '{2, 4};
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int k = 0; k < 8; k++)
        mm[w][k] = '{instr: NOP, bubble: 1'b1, dbg: 1'b0, res: 32'h0};
  endtask

  // History as a list with newest at the front.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int w = 0; w < 2; w++) begin
      if (flush) begin
        for (int k = 0; k < dep[w]; k++) mm[w][k].bubble = 1'b1;
      end else if (!stall) begin
        ment_t front;
        front.instr  = wb.instr;
        front.dbg    = wb.dbg;
        front.bubble = !we;
        front.res    = we ? wr : mm[w][0].res;
        for (int k = dep[w] - 1; k >= 1; k--) mm[w][k] = mm[w][k-1];
        mm[w][0] = front;
      end
    end
  endtask

  function automatic logic [32:0] ref_lookup(input int w, input logic [4:0] a);
    if (a == 5'd0) return 33'h0;
    for (int k = 0; k < dep[w]; k++)
      if (!mm[w][k].bubble && mm[w][k].instr[11:7] == a) return {1'b1, mm[w][k].res};
    return 33'h0;
  endfunction

  task automatic check_all();
    logic [32:0] e;
    for (int p = 0; p < 2; p++) begin
      e = ref_lookup(0, rs2[p]);
      check($sformatf("d2_hit%0d", p), 64'(hit2[p]), 64'(e[32]));
      check($sformatf("d2_r%0d", p), 64'(r2[p]), 64'(e[31:0]));
    end
    for (int p = 0; p < 3; p++) begin
      e = ref_lookup(1, rs4[p]);
      check($sformatf("d4_hit%0d", p), 64'(hit4[p]), 64'(e[32]));
      check($sformatf("d4_r%0d", p), 64'(r4[p]), 64'(e[31:0]));
    end
    check("d2_dwb_instr", 64'(dwb2.instr), 64'(mm[0][0].instr));
    check("d2_dwb_bubble", 64'(dwb2.bubble), 64'(mm[0][0].bubble));
    check("d2_dwb_dbg", 64'(dwb2.dbg), 64'(mm[0][0].dbg));
    check("d2_dwb_r", 64'(dwbr2), 64'(mm[0][0].res));
    check("d4_dwb_instr", 64'(dwb4.instr), 64'(mm[1][0].instr));
    check("d4_dwb_bubble", 64'(dwb4.bubble), 64'(mm[1][0].bubble));
    check("d4_dwb_dbg", 64'(dwb4.dbg), 64'(mm[1][0].dbg));
    check("d4_dwb_r", 64'(dwbr4), 64'(mm[1][0].res));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_wb(input logic w, input logic [4:0] rd, input logic [31:0] r);
    we       = w;
    wb.instr = {20'h0, rd, 7'h13};
    wb.dbg   = 1'b0;
    wb.bubble = 1'b0;
    wr       = r;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    rs2 = '0; rs4 = '0;
    model_reset();
    #12;
    check_all();
    check("rst_hit", 64'(hit2), 64'h0);
    check("rst_instr", 64'(dwb2.instr), 64'h13);
    check("rst_bubble", 64'(dwb2.bubble), 64'h1);
    check("rst_r", 64'(dwbr2), 64'h0);
    rst = 1'b0;

    // Shift and forward through a depth-2 history
    rs2[0] = 5'd5; rs4[0] = 5'd5;
    set_wb(1'b1, 5'd5, 32'h11); step();
    set_wb(1'b1, 5'd5, 32'h22); step();
    check("fwd_new_hit", 64'(hit2[0]), 64'h1);
    check("fwd_new_r", 64'(r2[0]), 64'h22);
    set_wb(1'b0, 5'd9, 32'h99); step();
    check("fwd_aged_hit", 64'(hit2[0]), 64'h1);
    check("fwd_aged_r", 64'(r2[0]), 64'h22);
    step(); step();
    check("fwd_gone_hit", 64'(hit2[0]), 64'h0);
    check("fwd_gone_r", 64'(r2[0]), 64'h0);

    // x0 never forwards
    rs2[1] = 5'd0; rs4[1] = 5'd0;
    set_wb(1'b1, 5'd0, 32'hFFFF_FFFF); step();
    check("x0_hit", 64'(hit2[1]), 64'h0);
    check("x0_r", 64'(r2[1]), 64'h0);

    // Stall freezes the history even with writes pending
    rs2[0] = 5'd3; rs4[0] = 5'd3;
    set_wb(1'b1, 5'd3, 32'hAB); step();
    stall = 1'b1;
    set_wb(1'b1, 5'd3, 32'hCD);
    repeat (3) step();
    check("stall_hit", 64'(hit2[0]), 64'h1);
    check("stall_r", 64'(r2[0]), 64'hAB);
    check("stall_dwb_r", 64'(dwbr2), 64'hAB);

    // Flush wins over stall and write
    stall = 1'b0;
    rs2[0] = 5'd7; rs4[0] = 5'd7;
    set_wb(1'b1, 5'd7, 32'h77); step();
    check("pre_flush_hit", 64'(hit2[0]), 64'h1);
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    check("flush_hit2", 64'(hit2[0]), 64'h0);
    check("flush_hit4", 64'(hit4[0]), 64'h0);
    check("flush_bubble", 64'(dwb2.bubble), 64'h1);

    // Reset asserted mid-stall takes effect without a clock edge
    set_wb(1'b1, 5'd7, 32'h55); step();
    stall = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("async_rst_bubble", 64'(dwb4.bubble), 64'h1);
    step();
    rst = 1'b0; stall = 1'b0;

    // Multi-port youngest-wins on the depth-4 instance
    rs4[0] = 5'd1; rs4[1] = 5'd2; rs4[2] = 5'd4;
    set_wb(1'b1, 5'd1, 32'h10); step();
    set_wb(1'b1, 5'd2, 32'h20); step();
    set_wb(1'b1, 5'd1, 32'h30); step();
    check("mp_hit0", 64'(hit4[0]), 64'h1);
    check("mp_r0", 64'(r4[0]), 64'h30);
    check("mp_hit1", 64'(hit4[1]), 64'h1);
    check("mp_r1", 64'(r4[1]), 64'h20);
    check("mp_hit2", 64'(hit4[2]), 64'h0);
    check("mp_r2", 64'(r4[2]), 64'h0);

    // Random traffic over a small register window to get frequent hits
    for (int i = 0; i < 500; i++) begin
      we    = 1'($urandom_range(0, 3) != 0);
      stall = 1'($urandom_range(0, 4) == 0);
      flush = 1'($urandom_range(0, 15) == 0);
      wb.instr  = {$urandom() & 32'hFFFF_F07F} | {20'h0, 5'($urandom_range(0, 7)), 7'h0};
      wb.dbg    = 1'($urandom_range(0, 1));
      wb.bubble = 1'($urandom_range(0, 1));
      wr = $urandom();
      for (int p = 0; p < 2; p++) rs2[p] = 5'($urandom_range(0, 7));
      for (int p = 0; p < 3; p++) rs4[p] = 5'($urandom_range(0, 7));
      #1;
      check_all();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_wb_history.md
RISCV_WB_HISTORY -- requirements
Module: riscv_wb_history

Interface
REQ-001 SHALL have parameter MXLEN, default 32: data width of writeback results.
REQ-002 SHALL have parameter DEPTH, default 2, legal 1..8: number of delayed writeback entries held.
REQ-003 SHALL have parameter NUM_RPORTS, default 2, legal 1..4: number of independent forwarding lookup ports.
REQ-004 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port stall_i  input  1  hold all history entries unchanged.
REQ-007 SHALL have port flush_i  input  1  invalidate the whole history.
REQ-008 SHALL have port wb_insn_i  input  instruction_t  writeback-stage instruction (instr, bubble, dbg).
REQ-009 SHALL have port wb_we_i  input  1  writeback register-file write enable.
REQ-010 SHALL have port wb_r_i  input  MXLEN  writeback result.
REQ-011 SHALL have port rs_addr_i  input  NUM_RPORTS x 5  source register address per lookup port.
REQ-012 SHALL have port fwd_hit_o  output  NUM_RPORTS  lookup hit per port.
REQ-013 SHALL have port fwd_r_o  output  NUM_RPORTS x MXLEN  forwarded result per port.
REQ-014 SHALL have port dwb_insn_o  output  instruction_t  entry 0 (youngest) instruction.
REQ-015 SHALL have port dwb_r_o  output  MXLEN  entry 0 result.

Function
REQ-016 SHALL hold entries 0..DEPTH-1, each: instr, bubble, dbg, rd (instr[11:7]), result; entry 0 youngest.
REQ-017 SHALL, on a clock edge with stall_i=0 and flush_i=0, shift entry k to k+1 (entry DEPTH-1 discarded) and load entry 0 from wb_insn_i.instr, wb_insn_i.dbg, wb_r_i, with bubble = ~wb_we_i.
REQ-018 SHALL, with stall_i=1 and flush_i=0, keep every entry unchanged, regardless of wb_we_i.
REQ-019 SHALL, with flush_i=1, set bubble=1 in all entries including entry 0 on that edge; flush overrides stall and shift; instr, dbg, result fields are don't-care-but-kept.
REQ-020 SHALL write an entry's result field only when that entry loads with wb_we_i=1 or shifts; a bubble load keeps prior result bits (no requirement on value).
REQ-021 SHALL compute lookups combinationally: port p hits when some entry has bubble=0 and rd == rs_addr_i[p] and rs_addr_i[p] != 0.
REQ-022 SHALL, on multiple matching entries, forward the result of the lowest-index (youngest) match.
REQ-023 SHALL drive fwd_r_o[p] = 0 when fwd_hit_o[p]=0.
REQ-024 SHALL never hit on register x0, even if an entry with rd=0 and bubble=0 exists.
REQ-025 SHALL ignore the write-back path in lookups: wb_* inputs of the current cycle are not forwarded (latency 1 cycle to visibility).
REQ-026 SHALL drive dwb_insn_o/dwb_r_o from entry 0 directly, no extra latency.
REQ-027 SHALL with DEPTH=1 behave as a single delay stage plus stall/flush and lookup.

Reset
REQ-028 SHALL, while rst_i=1, asynchronously force every entry: instr=NOP, bubble=1, dbg=0, result=0.
REQ-029 SHALL, after reset, give fwd_hit_o=0, fwd_r_o=0, dwb_insn_o.instr=NOP, dwb_insn_o.bubble=1, dwb_r_o=0.
REQ-030 SHALL, on reset asserted mid-stall or mid-flush, apply reset values immediately; first non-reset edge follows REQ-017..019.

Structure
REQ-031 SHALL import riscv_opcodes_pkg (NOP) and riscv_state_pkg (instruction_t); entry record typedef and rd field position constants SHALL live in riscv_state_pkg.
REQ-032 SHALL be one module, no sub-modules; lookup is a generate loop over NUM_RPORTS with priority search over DEPTH.

Verification
REQ-033 Reset: rst_i=1 then 0, no writes -> fwd_hit_o=0, dwb_insn_o.bubble=1, dwb_r_o=0, instr=NOP.
REQ-034 Shift/forward: DEPTH=2; write rd=5,r=0x11 then rd=5,r=0x22; rs_addr_i[0]=5 -> hit, 0x22; next cycle bubble (we=0) -> still hit 0x22; two more bubbles -> hit=0.
REQ-035 x0: write rd=0,r=0xFFFF_FFFF, rs_addr_i[1]=0 -> fwd_hit_o[1]=0, fwd_r_o[1]=0.
REQ-036 Stall: write rd=3,r=0xAB, then stall_i=1 for 3 cycles with wb_we_i=1, rd=3,r=0xCD -> hit stays 0xAB, dwb_r_o=0xAB.
REQ-037 Flush: entries rd=7 valid, flush_i=1 with stall_i=1 and wb_we_i=1 -> next cycle all bubble, rs_addr 7 -> hit=0.
REQ-038 Multi-port/depth: DEPTH=4, NUM_RPORTS=3; writes rd=1,2,1 (0x10,0x20,0x30) -> ports {1,2,4} give {hit 0x30, hit 0x20, miss 0}.
